// File: rtl/route_allocator.sv
// Output-port allocator for a mesh NoC switch: round-robin arbitration per output,
// with wormhole reservation held until the owning input relieves it.
module route_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req_valid,
  input  logic [N*REQUEST_WIDTH-1:0] req_port,
  input  logic [N-1:0]               relieve,
  output logic [N-1:0]               grant,
  output logic [N*$clog2(N)-1:0]     sel,
  output logic [N-1:0]               conn_valid
);

  localparam int SW = $clog2(N);

  localparam logic [0:0] FREE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [N-1:0]         state_q, state_d;
  logic [SW-1:0]        owner_q [N];
  logic [SW-1:0]        owner_d [N];
  logic [SW-1:0]        ptr_q   [N];
  logic [SW-1:0]        ptr_d   [N];
  logic [N-1:0]         grant_q, grant_d;

  logic [REQUEST_WIDTH-1:0] reqPort [N];
  logic [N-1:0]             owns;
  logic [N-1:0]             elig [N];

  logic found;
  int   winner;
  int   idx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      reqPort[i] = req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH];
    end
  end

  // An input holding any output must not win another; this also masks its stale request.
  always_comb begin
    owns = '0;
    for (int o = 0; o < N; o++) begin
      if (state_q[o] == BUSY) begin
        owns[owner_q[o]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        elig[o][i] = req_valid[i] && (int'(reqPort[i]) == o) && (state_q[o] == FREE) &&
                     !grant_q[i] && !owns[i];
      end
    end
  end

  // A BUSY output only listens to its owner's relieve, so a freed output arbitrates next cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    found   = 1'b0;
    winner  = 0;
    idx     = 0;
    for (int o = 0; o < N; o++) begin
      found  = 1'b0;
      winner = 0;
      if (state_q[o] == BUSY) begin
        if (relieve[owner_q[o]]) begin
          state_d[o] = FREE;
          owner_d[o] = '0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(ptr_q[o]) + k) % N;
          if (!found && elig[o][idx]) begin
            found  = 1'b1;
            winner = idx;
          end
        end
        if (found) begin
          state_d[o]      = BUSY;
          owner_d[o]      = SW'(winner);
          ptr_d[o]        = SW'((winner + 1) % N);
          grant_d[winner] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      grant_q <= '0;
      for (int o = 0; o < N; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      for (int o = 0; o < N; o++) begin
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Owner is cleared on free, so the select reads zero whenever the output is not reserved.
  always_comb begin
    sel = '0;
    for (int o = 0; o < N; o++) begin
      sel[o*SW +: SW] = owner_q[o];
    end
  end

  assign grant      = grant_q;
  assign conn_valid = state_q;

endmodule
